// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the multicycle RV32I controller.
//   - state encodings (FETCH encodes as 0 so a zeroed state_o reads as FETCH)
//   - supported opcode values
//   - mux/ALU select field encodings
//   - ctrl_t: the decoded control word produced per state
package ctrl_pkg;

  // State encodings
  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] EXEC_R    = 4'd6;
  localparam logic [3:0] EXEC_I    = 4'd7;
  localparam logic [3:0] ALU_WB    = 4'd8;
  localparam logic [3:0] BRANCH    = 4'd9;
  localparam logic [3:0] JAL       = 4'd10;
  localparam logic [3:0] LUI       = 4'd11;

  // Opcodes
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // Select encodings
  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_REGA  = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;

  localparam logic [1:0] B_REGB = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_JAL) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/ctrl_out_dec.sv
// ctrl_out_dec: combinational state -> control word decoder.
//   state_i      current FSM state
//   mem_ready_i  memory handshake (FETCH commits IR and PC only when ready)
//   ctrl_o       decoded strobes and selects; unlisted fields are 0
module ctrl_out_dec
  import ctrl_pkg::*;
#(
  parameter int ST_W = 4
) (
  input  logic [ST_W-1:0] state_i,
  input  logic            mem_ready_i,
  output ctrl_t           ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.adr_src    = ADR_PC;
        ctrl_o.alu_src_a  = A_PC;
        ctrl_o.alu_src_b  = B_FOUR;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.result_src = RES_ALURESULT;
        ctrl_o.ir_write   = mem_ready_i;
        ctrl_o.pc_write   = mem_ready_i;
      end
      DECODE: begin
        // Precompute branch/jump target into ALUOut
        ctrl_o.alu_src_a = A_OLDPC;
        ctrl_o.alu_src_b = B_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      MEM_ADDR: begin
        ctrl_o.alu_src_a = A_REGA;
        ctrl_o.alu_src_b = B_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      MEM_READ: begin
        ctrl_o.adr_src = ADR_ALUOUT;
      end
      MEM_WB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        // Strobe held for every wait cycle until memory accepts
        ctrl_o.adr_src   = ADR_ALUOUT;
        ctrl_o.mem_write = 1'b1;
      end
      EXEC_R: begin
        ctrl_o.alu_src_a = A_REGA;
        ctrl_o.alu_src_b = B_REGB;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      EXEC_I: begin
        ctrl_o.alu_src_a = A_REGA;
        ctrl_o.alu_src_b = B_IMM;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      ALU_WB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a  = A_REGA;
        ctrl_o.alu_src_b  = B_REGB;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.branch     = 1'b1;
      end
      JAL: begin
        // ALU computes OldPC+4 for rd while PC loads target from ALUOut
        ctrl_o.alu_src_a  = A_OLDPC;
        ctrl_o.alu_src_b  = B_FOUR;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.pc_write   = 1'b1;
      end
      LUI: begin
        ctrl_o.alu_src_a = A_ZERO;
        ctrl_o.alu_src_b = B_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing the multicycle RV32I datapath.
//   clk, rst         rising-edge clock, synchronous active-low reset
//   opcode_i         instr[6:0] from IR buffer
//   zero_i           ALU zero flag (only affects pc_en_o)
//   mem_ready_i      memory access completes this cycle
//   pc_en_o ..       datapath strobes and selects
//   illegal_o        pulse in DECODE on an unsupported opcode
//   state_o          current state for debug
// All outputs are forced to 0 while rst is low.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W = 7,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            pc_en_o,
  output logic            ir_write_o,
  output logic            reg_write_o,
  output logic            mem_write_o,
  output logic            adr_src_o,
  output logic [1:0]      alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [1:0]      alu_op_o,
  output logic [1:0]      result_src_o,
  output logic            illegal_o,
  output logic [ST_W-1:0] state_o
);

  logic [ST_W-1:0] state_q, state_d;
  ctrl_t           ctrl;
  logic            op_legal;

  assign op_legal = is_legal(opcode_i);

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ready_i ? DECODE : FETCH;
      DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_R:         state_d = EXEC_R;
          OP_I:         state_d = EXEC_I;
          OP_BEQ:       state_d = BRANCH;
          OP_JAL:       state_d = JAL;
          OP_LUI:       state_d = LUI;
          default:      state_d = FETCH;
        endcase
      end
      MEM_ADDR:  state_d = (opcode_i == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  state_d = mem_ready_i ? MEM_WB : MEM_READ;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: state_d = mem_ready_i ? FETCH : MEM_WRITE;
      EXEC_R:    state_d = ALU_WB;
      EXEC_I:    state_d = ALU_WB;
      ALU_WB:    state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JAL:       state_d = ALU_WB;
      LUI:       state_d = ALU_WB;
      default:   state_d = FETCH; // unused encodings recover
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  ctrl_out_dec #(.ST_W(ST_W)) u_dec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl)
  );

  // Gating with rst kills any in-flight strobe the same cycle reset asserts
  assign pc_en_o      = rst & (ctrl.pc_write | (ctrl.branch & zero_i));
  assign ir_write_o   = rst & ctrl.ir_write;
  assign reg_write_o  = rst & ctrl.reg_write;
  assign mem_write_o  = rst & ctrl.mem_write;
  assign adr_src_o    = rst & ctrl.adr_src;
  assign alu_src_a_o  = rst ? ctrl.alu_src_a  : 2'b00;
  assign alu_src_b_o  = rst ? ctrl.alu_src_b  : 2'b00;
  assign alu_op_o     = rst ? ctrl.alu_op     : 2'b00;
  assign result_src_o = rst ? ctrl.result_src : 2'b00;
  assign illegal_o    = rst & (state_q == DECODE) & ~op_legal;
  assign state_o      = rst ? state_q : '0;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM that sequences the multicycle RV32I datapath. It generates the enable strobes for the PC, IR/OldPC and register-file write buffers, the memory write strobe, and the mux/ALU selects.
- It sits beside the datapath. It consumes the fetched opcode, the ALU zero flag and a memory-ready handshake.
- Supported opcodes: R-type, I-type ALU, LW, SW, BEQ, JAL, LUI.

Parameters:
- OP_W, 7, opcode field width.
- ST_W, 4, state register width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset.
- opcode_i  input  OP_W  instr[6:0] from the IR buffer output.
- zero_i  input  1  ALU zero flag.
- mem_ready_i  input  1  memory access completes this cycle.
- pc_en_o  output  1  PC buffer enable, equal to pc_write OR (branch AND zero_i).
- ir_write_o  output  1  IR/OldPC buffer enable.
- reg_write_o  output  1  register-file write enable.
- mem_write_o  output  1  data-memory write strobe.
- adr_src_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
- alu_src_a_o  output  2  ALU A select: 00 PC, 01 OldPC, 10 reg A, 11 zero.
- alu_src_b_o  output  2  ALU B select: 00 reg B, 01 Imm, 10 constant 4.
- alu_op_o  output  2  ALU op: 00 add, 01 sub, 10 funct-decoded.
- result_src_o  output  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
- illegal_o  output  1  one-cycle pulse on an unsupported opcode in DECODE.
- state_o  output  ST_W  current state, for debug.

Behaviour:
- State register only changes on posedge clk. If rst==0 at the edge, state becomes FETCH.
- While rst==0, every output is forced to 0 combinationally, including state_o (FETCH encodes as 0). Reset asserted mid-instruction aborts it; no partial write completes after the edge.
- Outputs are Moore, decoded from state. The only exception is pc_en_o, which also uses zero_i.
- Any select not listed for a state is 00/0. Any strobe not listed is 0.
- FETCH:
  - adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - ir_write and pc_write are both equal to mem_ready_i.
  - Stays in FETCH while !mem_ready_i; goes to DECODE when mem_ready_i=1.
- DECODE:
  - a=01, b=01, add (branch/jump target into ALUOut).
  - LW/SW go to MEM_ADDR; R goes to EXEC_R; I-ALU goes to EXEC_I; BEQ goes to BRANCH; JAL goes to JAL; LUI goes to LUI.
  - Any other opcode: illegal_o=1, next state FETCH.
- MEM_ADDR: a=10, b=01, add. Next state is MEM_READ if opcode LW, else MEM_WRITE.
- MEM_READ: adr_src=1. Holds until mem_ready_i, then goes to MEM_WB.
- MEM_WB: result_src=01, reg_write=1, next FETCH.
- MEM_WRITE: adr_src=1, mem_write=1. Held until mem_ready_i, then FETCH. The strobe stays high for every wait cycle.
- EXEC_R: a=10, b=00, alu_op=10, next ALU_WB.
- EXEC_I: a=10, b=01, alu_op=10, next ALU_WB.
- ALU_WB: result_src=00, reg_write=1, next FETCH.
- BRANCH:
  - a=10, b=00, alu_op=01, result_src=00, branch=1.
  - pc_en_o = zero_i. Next FETCH.
- JAL: a=01, b=10, add, result_src=00, pc_write=1, next ALU_WB. PC takes the target; rd receives OldPC+4.
- LUI: a=11, b=01, add, next ALU_WB.
- Latency with mem_ready_i tied high:
  - BEQ: 3 cycles.
  - R-type, I-type, LUI, JAL: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1.
- Unused state encodings go to FETCH on the next edge with all strobes 0.

Decomposition:
- Package ctrl_pkg holds:
  - state localparams: FETCH=0, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, LUI;
  - opcode constants: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 0110111;
  - encodings for the select fields.
- One sub-module, ctrl_out_dec: a purely combinational state-to-controls decoder.
- The next-state logic and state register stay in the top module.

Test Plan:
- rst=0 for 2 cycles, with mem_ready_i=1 and opcode 0110011 -> state_o=0 and all strobes 0. After release: FETCH, DECODE, EXEC_R, ALU_WB; reg_write_o=1 in cycle 4 only.
- LW (0000011) with mem_ready_i low for 2 cycles in MEM_READ -> MEM_READ held 3 cycles; reg_write_o with result_src_o=01 exactly once; total 7 cycles.
- SW (0100011) -> mem_write_o=1 and adr_src_o=1 only in MEM_WRITE; reg_write_o never 1.
- BEQ (1100011) with zero_i=1, then again with zero_i=0 -> pc_en_o=1 in BRANCH for the first run and 0 for the second; alu_op_o=01.
- Opcode 1111111 -> illegal_o pulse in DECODE, then FETCH; no reg_write_o or mem_write_o.
- rst driven 0 during MEM_WRITE while mem_ready_i=0 -> mem_write_o drops in the same cycle; next state is FETCH.
